// File: rtl/jtframe_kabuki_keyload.sv
// Kabuki key loader.
// Captures the 11 key bytes from the ROM download stream, in any order and
// with repeats allowed, and replays them to the decoder's key shift register
// in ascending index order once the download has ended. Decryption is only
// enabled after a complete key set has been shifted in.
module jtframe_kabuki_keyload #(
  parameter int             AW       = 25,
  parameter logic [AW-1:0]  KEY_ADDR = '0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          en,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, DONE} state_t;

  state_t      state_q;
  logic [7:0]  key_q [0:10];
  logic [10:0] valid_q;
  logic [10:0] valid_d;
  logic [3:0]  rcnt_q;
  logic        dl_q;
  logic        fall_q;

  // The extra top bit of the difference is the borrow, so an address below
  // KEY_ADDR can never wrap around into the key window.
  logic [AW:0] diff;
  logic        hit;
  logic [3:0]  widx;
  logic        enter_cap;

  // Key window decode and next value of the valid mask.
  always_comb begin
    diff      = {1'b0, ioctl_addr} - {1'b0, KEY_ADDR};
    hit       = downloading && ioctl_wr && !diff[AW] && (diff[AW-1:0] <= AW'(10));
    widx      = diff[3:0];
    // Every entry into CAPTURE starts a fresh key set; a write in that same
    // cycle still counts.
    enter_cap = downloading && (state_q != CAPTURE);
    valid_d   = enter_cap ? 11'h000 : valid_q;
    if (hit) begin
      valid_d[widx] = 1'b1;
    end
  end

  // Key storage: plain write port, read happens through the registered prog_data.
  always_ff @(posedge clk) begin
    if (hit) begin
      key_q[widx] <= ioctl_dout;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 11'h000;
      rcnt_q    <= 4'd0;
      dl_q      <= 1'b0;
      fall_q    <= 1'b0;
      prog_data <= 8'h00;
      prog_we   <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dl_q    <= downloading;
      fall_q  <= dl_q & ~downloading;
      valid_q <= valid_d;
      case (state_q)
        IDLE: begin
          if (downloading) begin
            state_q <= CAPTURE;
            prog_we <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          // Deciding one cycle after the fall lets a last-cycle byte count.
          if (fall_q) begin
            if (valid_q == 11'h7FF) begin
              state_q   <= REPLAY;
              rcnt_q    <= 4'd0;
              prog_data <= key_q[0];
              prog_we   <= 1'b1;
              busy      <= 1'b1;
            end else begin
              // Incomplete key: leave the decoder in plaintext bypass.
              state_q <= IDLE;
              en      <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        REPLAY: begin
          if (downloading) begin
            state_q <= CAPTURE;
            prog_we <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b1;
          end else if (rcnt_q == 4'd10) begin
            state_q <= DONE;
            prog_we <= 1'b0;
            en      <= 1'b1;
            busy    <= 1'b0;
          end else begin
            rcnt_q    <= rcnt_q + 4'd1;
            prog_data <= key_q[rcnt_q + 4'd1];
            prog_we   <= 1'b1;
          end
        end
        DONE: begin
          if (downloading) begin
            state_q <= CAPTURE;
            prog_we <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          prog_we <= 1'b0;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_kabuki_keyload.sv
// Bench for the Kabuki key loader: directed scenarios plus randomized
// downloads, checked against a simple key/valid model of the download.
module tb_jtframe_kabuki_keyload;

  localparam int            AW = 25;
  localparam logic [AW-1:0] KA = 25'h100;

  logic          rst;
  logic          clk = 1'b0;
  logic          downloading = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    prog_data;
  logic          prog_we;
  logic          en;
  logic          busy;

  jtframe_kabuki_keyload #(.AW(AW), .KEY_ADDR(KA)) dut (
    .rst         (rst),
    .clk         (clk),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_data   (prog_data),
    .prog_we     (prog_we),
    .en          (en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_key [11];
  bit         m_valid [11];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 11; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 11; i++) f = f & m_valid[i];
    return f;
  endfunction

  // Raise downloading; the loader must drop en/prog_we and report busy.
  task automatic begin_dl(input string name);
    downloading = 1'b1;
    model_clear();
    step();
    check({name, "_enter_en"},   32'(en),      32'd0);
    check({name, "_enter_we"},   32'(prog_we), 32'd0);
    check({name, "_enter_busy"}, 32'(busy),    32'd1);
  endtask

  // One download byte; the model keeps the last write per in-window index.
  task automatic wr(input int a, input logic [7:0] d);
    ioctl_addr = AW'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
    if (a >= int'(KA) && a <= int'(KA) + 10) begin
      m_key[a - int'(KA)]   = d;
      m_valid[a - int'(KA)] = 1'b1;
    end
  endtask

  // Drop downloading and check the next ncyc cycles: with a complete key,
  // strobes on cycles 2..12 after the drop carrying bytes 0..10, en from 13.
  task automatic end_dl(input string name, input int ncyc);
    bit full;
    bit exp_we;
    downloading = 1'b0;
    full = m_full();
    for (int n = 1; n <= ncyc; n++) begin
      step();
      exp_we = full && (n >= 2) && (n <= 12);
      check({name, "_we"}, 32'(prog_we), 32'(exp_we));
      if (exp_we) check({name, "_data"}, 32'(prog_data), 32'(m_key[n - 2]));
      check({name, "_en"},   32'(en),   32'(full && (n >= 13)));
      check({name, "_busy"}, 32'(busy), 32'((n == 1) || (full && (n <= 12))));
    end
  endtask

  task automatic full_key(input logic [7:0] base);
    for (int i = 0; i < 11; i++) wr(int'(KA) + i, base + 8'(i));
  endtask

  initial begin
    int a;
    int nw;
    int sel;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("reset_we",   32'(prog_we),   32'd0);
    check("reset_en",   32'(en),        32'd0);
    check("reset_data", 32'(prog_data), 32'h00);
    check("reset_busy", 32'(busy),      32'd0);
    rst = 1'b0;
    step();

    // Nominal in-order download
    begin_dl("nominal");
    full_key(8'h10);
    end_dl("nominal", 16);

    // Out-of-order and duplicate writes (also leaves DONE via a new download)
    begin_dl("dup");
    wr(int'(KA) + 10, 8'hAA);
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        wr(int'(KA) + 3, 8'h33);
        wr(int'(KA) + 3, 8'h3C);
      end else begin
        wr(int'(KA) + i, 8'h40 + 8'(i));
      end
    end
    end_dl("dup", 16);

    // Missing index 7: bypass, back to idle
    begin_dl("missing");
    for (int i = 0; i < 11; i++) if (i != 7) wr(int'(KA) + i, 8'h70 + 8'(i));
    end_dl("missing", 20);

    // Window edges around a complete key
    begin_dl("edge");
    wr(int'(KA) - 1, 8'hEE);
    wr(0, 8'hE0);
    for (int i = 0; i < 11; i++) wr(int'(KA) + i, 8'($urandom));
    wr(int'(KA) + 11, 8'hEF);
    wr(int'(KA) - 1, 8'hED);
    end_dl("edge", 16);

    // Window edges must not fill the missing end indices
    begin_dl("edge_miss");
    wr(int'(KA) - 1, 8'h5A);
    for (int i = 1; i < 10; i++) wr(int'(KA) + i, 8'h80 + 8'(i));
    wr(int'(KA) + 11, 8'hA5);
    end_dl("edge_miss", 20);

    // Randomized downloads, half of them completed
    for (int r = 0; r < 6; r++) begin
      begin_dl("rand");
      nw = int'($urandom_range(8, 24));
      for (int k = 0; k < nw; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       a = int'(KA) + int'($urandom_range(0, 10));
        else if (sel == 7) a = int'(KA) - 1 - int'($urandom_range(0, 3));
        else               a = int'(KA) + 11 + int'($urandom_range(0, 3));
        wr(a, 8'($urandom));
        if ($urandom_range(0, 3) == 0) step();
      end
      if (r % 2 == 0) begin
        for (int i = 0; i < 11; i++) if (!m_valid[i]) wr(int'(KA) + i, 8'($urandom));
      end
      end_dl("rand", 16);
    end

    // Abort at the 5th strobe, then a fresh download
    begin_dl("abort_pre");
    full_key(8'hC0);
    end_dl("abort_pre", 6);
    downloading = 1'b1;
    model_clear();
    step();
    check("abort_we",   32'(prog_we), 32'd0);
    check("abort_en",   32'(en),      32'd0);
    check("abort_busy", 32'(busy),    32'd1);
    full_key(8'hD0);
    end_dl("abort_post", 16);

    // Asynchronous reset mid-replay
    begin_dl("rst_pre");
    full_key(8'h20);
    end_dl("rst_pre", 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",   32'(prog_we),   32'd0);
    check("arst_en",   32'(en),        32'd0);
    check("arst_data", 32'(prog_data), 32'h00);
    check("arst_busy", 32'(busy),      32'd0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      check("post_rst_we", 32'(prog_we), 32'd0);
      check("post_rst_en", 32'(en),      32'd0);
    end
    begin_dl("post_rst_part");
    for (int i = 0; i < 10; i++) wr(int'(KA) + i, 8'h90 + 8'(i));
    end_dl("post_rst_part", 20);
    begin_dl("post_rst_full");
    full_key(8'hB0);
    end_dl("post_rst_full", 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
